mem_stage: RTL and testbench

//  Memory-access pipeline stage between EXE and WB. Accepts one instruction per handshake from EXE.

---
 rtl/mem_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EXE and WB.
// Holds one instruction, waits for the data-SRAM response of a load or store,
// extracts and extends load data, and discards responses owed to flushed instructions.
// Optional build macro MEM_STAGE_FWD_EN drives the ms_fwd_* outputs; when it is
// undefined those outputs are tied to 0.
module mem_stage #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es2ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic        es_mem_req,
    input  logic [4:0]  es_ld_op,
    input  logic        es_rf_we,
    input  logic [4:0]  es_rf_waddr,
    input  logic [31:0] es_result,
    input  logic        es_ex,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    output logic        ms2ws_valid,
    output logic [31:0] ms_pc,
    output logic        ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic [31:0] ms_rf_wdata,
    output logic        ms_ex,
    output logic        ms_ld_block,
    input  logic        wb_ex,
    output logic        ms_fwd_valid,
    output logic [31:0] ms_fwd_data
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    // Select the addressed byte/half lane and extend it; op is {b, bu, h, hu, w}.
    function automatic logic [31:0] load_extract(input logic [4:0]  op,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic        [31:0] sh;
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        logic signed [31:0] ext;
        sh  = word >> {lane, 3'b000};
        b8  = sh[7:0];
        h16 = sh[15:0];
        ext = signed'(word);
        if (op[4])      ext = 32'(b8);
        else if (op[3]) ext = signed'({24'b0, sh[7:0]});
        else if (op[2]) ext = 32'(h16);
        else if (op[1]) ext = signed'({16'b0, sh[15:0]});
        return unsigned'(ext);
    endfunction

    // Saturating up/down step of the stale-response counter.
    function automatic logic [CNT_W-1:0] drop_next(input logic [CNT_W-1:0] cnt,
                                                   input logic             inc,
                                                   input logic             dec);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec && cnt != CNT_MAX) nxt = cnt + 1'b1;
        else if (dec && !inc)              nxt = cnt - 1'b1;
        return nxt;
    endfunction

    // ---- MEM stage registers (p1) ----
    logic             vld_p1;
    logic [31:0]      pc_p1;
    logic             mem_req_p1;
    logic [4:0]       ld_op_p1;
    logic             rf_we_p1;
    logic [4:0]       rf_waddr_p1;
    logic [31:0]      result_p1;
    logic             ex_p1;
    logic             buf_vld_p1;
    logic [31:0]      buf_p1;
    logic [CNT_W-1:0] drop_cnt;

    logic        resp_hit;
    logic        ms_ready_go;
    logic        is_load;
    logic        leave;
    logic        drop_inc;
    logic        drop_dec;
    logic [31:0] rdata_sel;

    assign resp_hit    = data_sram_data_ok && (drop_cnt == '0);
    assign ms_ready_go = !mem_req_p1 || buf_vld_p1 || resp_hit;
    assign ms_allowin  = !vld_p1 || (ms_ready_go && ws_allowin);
    assign ms2ws_valid = vld_p1 && ms_ready_go;
    assign leave       = ms2ws_valid && ws_allowin;
    assign is_load     = |ld_op_p1;
    assign rdata_sel   = buf_vld_p1 ? buf_p1 : data_sram_rdata;

    // A flushed memory instruction with no response yet still owes one data_ok.
    assign drop_inc = wb_ex && vld_p1 && mem_req_p1 && !buf_vld_p1 && !resp_hit;
    assign drop_dec = data_sram_data_ok && (drop_cnt != '0);

    assign ms_pc       = pc_p1;
    assign ms_rf_we    = vld_p1 && rf_we_p1;
    assign ms_rf_waddr = rf_waddr_p1;
    assign ms_rf_wdata = is_load ? load_extract(ld_op_p1, result_p1[1:0], rdata_sel) : result_p1;
    assign ms_ex       = vld_p1 && ex_p1;
    assign ms_ld_block = vld_p1 && is_load && !ms_ready_go;

`ifdef MEM_STAGE_FWD_EN
    assign ms_fwd_valid = vld_p1 && rf_we_p1 && ms_ready_go;
    assign ms_fwd_data  = ms_rf_wdata;
`else
    assign ms_fwd_valid = 1'b0;
    assign ms_fwd_data  = 32'h0;
`endif

    // Stage occupancy: flush wins, otherwise follow EXE when we can accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         vld_p1 <= 1'b0;
        else if (wb_ex)      vld_p1 <= 1'b0;
        else if (ms_allowin) vld_p1 <= es2ms_valid;
    end

    // Capture instruction fields on a successful EXE->MEM handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_p1       <= 32'h0;
            mem_req_p1  <= 1'b0;
            ld_op_p1    <= 5'h0;
            rf_we_p1    <= 1'b0;
            rf_waddr_p1 <= 5'h0;
            result_p1   <= 32'h0;
            ex_p1       <= 1'b0;
        end else if (es2ms_valid && ms_allowin) begin
            pc_p1       <= es_pc;
            mem_req_p1  <= es_mem_req;
            ld_op_p1    <= es_ld_op;
            rf_we_p1    <= es_rf_we;
            rf_waddr_p1 <= es_rf_waddr;
            result_p1   <= es_result;
            ex_p1       <= es_ex;
        end
    end

    // Hold a response that arrived while WB was stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_vld_p1 <= 1'b0;
            buf_p1     <= 32'h0;
        end else if (wb_ex || leave) begin
            buf_vld_p1 <= 1'b0;
        end else if (resp_hit && vld_p1) begin
            buf_vld_p1 <= 1'b1;
            buf_p1     <= data_sram_rdata;
        end
    end

    // Count responses still owed to flushed instructions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) drop_cnt <= '0;
        else         drop_cnt <= drop_next(drop_cnt, drop_inc, drop_dec);
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for extraction/latency plus
// hand-written sequences for buffering, flush/drop, exceptions and async reset.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        es2ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic        es_mem_req;
    logic [4:0]  es_ld_op;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [31:0] es_result;
    logic        es_ex;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms2ws_valid;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_ex;
    logic        ms_ld_block;
    logic        wb_ex;
    logic        ms_fwd_valid;
    logic [31:0] ms_fwd_data;

    int total = 0;
    int bad   = 0;

    mem_stage #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_mem_req(es_mem_req), .es_ld_op(es_ld_op),
        .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_result(es_result),
        .es_ex(es_ex), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin),
        .ms2ws_valid(ms2ws_valid), .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
        .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata), .ms_ex(ms_ex),
        .ms_ld_block(ms_ld_block), .wb_ex(wb_ex),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_data(ms_fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mem_req;
        logic [4:0]  ld_op;
        logic        rf_we;
        logic [31:0] result;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until MEM accepts it (bounded).
    task automatic issue(input logic [31:0] pc, input logic mem_req, input logic [4:0] ld_op,
                         input logic rf_we, input logic [31:0] result, input logic ex);
        int n;
        es_pc       = pc;
        es_mem_req  = mem_req;
        es_ld_op    = ld_op;
        es_rf_we    = rf_we;
        es_rf_waddr = 5'd7;
        es_result   = result;
        es_ex       = ex;
        es2ms_valid = 1'b1;
        #1;
        n = 0;
        while (!ms_allowin && n < 20) begin
            tick();
            n++;
        end
        chk("issue_allowin", {31'b0, ms_allowin}, 32'd1);
        @(posedge clk);
        #1;
        es2ms_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_fv;
        logic [31:0] exp_fd;

        vecs[0]  = '{1'b0, 5'b00000, 1'b1, 32'h0000_1234, 32'h0,          0, 32'h0000_1234};
        vecs[1]  = '{1'b1, 5'b10000, 1'b1, 32'h0000_2003, 32'h80FF_FF7F,  3, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 5'b01000, 1'b1, 32'h0000_2003, 32'h80FF_FF7F,  3, 32'h0000_0080};
        vecs[3]  = '{1'b1, 5'b00100, 1'b1, 32'h0000_2002, 32'h8001_0000,  1, 32'hFFFF_8001};
        vecs[4]  = '{1'b1, 5'b00010, 1'b1, 32'h0000_2002, 32'h8001_0000,  2, 32'h0000_8001};
        vecs[5]  = '{1'b1, 5'b00001, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 5'b10000, 1'b1, 32'h0000_2000, 32'h1234_5678,  1, 32'h0000_0078};
        vecs[7]  = '{1'b1, 5'b10000, 1'b1, 32'h0000_2001, 32'h1234_5678,  1, 32'h0000_0056};
        vecs[8]  = '{1'b1, 5'b00100, 1'b1, 32'h0000_2000, 32'h0000_7FFF,  1, 32'h0000_7FFF};
        vecs[9]  = '{1'b1, 5'b10000, 1'b1, 32'h0000_2002, 32'h0080_0000,  1, 32'hFFFF_FF80};
        vecs[10] = '{1'b1, 5'b00000, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF,  2, 32'h0000_0100};
        vecs[11] = '{1'b0, 5'b00000, 1'b1, 32'hFFFF_0000, 32'h0,          0, 32'hFFFF_0000};

        resetn = 1'b0; es2ms_valid = 1'b0; es_pc = 32'h0; es_mem_req = 1'b0;
        es_ld_op = 5'h0; es_rf_we = 1'b0; es_rf_waddr = 5'h0; es_result = 32'h0;
        es_ex = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        ws_allowin = 1'b1; wb_ex = 1'b0;

        // Reset state
        #3;
        chk("rst_ms2ws_valid", {31'b0, ms2ws_valid}, 32'd0);
        chk("rst_ms_ex",       {31'b0, ms_ex},       32'd0);
        chk("rst_ld_block",    {31'b0, ms_ld_block}, 32'd0);
        chk("rst_allowin",     {31'b0, ms_allowin},  32'd1);
        chk("rst_pc",          ms_pc,                32'd0);
        chk("rst_fwd_valid",   {31'b0, ms_fwd_valid}, 32'd0);
        #10;
        resetn = 1'b1;
        tick();

        // Table: latency and extraction
        for (int i = 0; i < 12; i++) begin
            issue(32'h1C00_0000 + 32'(i * 4), vecs[i].mem_req, vecs[i].ld_op,
                  vecs[i].rf_we, vecs[i].result, 1'b0);
            if (vecs[i].mem_req) begin
                for (int k = 0; k < vecs[i].dly; k++) begin
                    data_sram_data_ok = 1'b0;
                    data_sram_rdata   = 32'h5A5A_5A5A;
                    #1;
                    if (k == 0) begin
                        chk($sformatf("v%0d_wait_valid", i), {31'b0, ms2ws_valid}, 32'd0);
                        chk($sformatf("v%0d_ld_block", i), {31'b0, ms_ld_block},
                            {31'b0, |vecs[i].ld_op});
                    end
                    tick();
                end
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = vecs[i].rdata;
            end
            #1;
            exp_fv = 1'b0;
            exp_fd = 32'h0;
`ifdef MEM_STAGE_FWD_EN
            exp_fv = vecs[i].rf_we;
            exp_fd = vecs[i].exp;
`endif
            chk($sformatf("v%0d_valid", i), {31'b0, ms2ws_valid}, 32'd1);
            chk($sformatf("v%0d_wdata", i), ms_rf_wdata, vecs[i].exp);
            chk($sformatf("v%0d_pc", i), ms_pc, 32'h1C00_0000 + 32'(i * 4));
            chk($sformatf("v%0d_rf_we", i), {31'b0, ms_rf_we}, {31'b0, vecs[i].rf_we});
            chk($sformatf("v%0d_ld_block_done", i), {31'b0, ms_ld_block}, 32'd0);
            chk($sformatf("v%0d_fwd_valid", i), {31'b0, ms_fwd_valid}, {31'b0, exp_fv});
            if (exp_fv) chk($sformatf("v%0d_fwd_data", i), ms_fwd_data, exp_fd);
            tick();
            data_sram_data_ok = 1'b0;
            #1;
            chk($sformatf("v%0d_left", i), {31'b0, ms2ws_valid}, 32'd0);
        end

        // Response arrives while WB stalls: buffered data survives rdata changes
        ws_allowin = 1'b0;
        issue(32'h1C00_0100, 1'b1, 5'b00100, 1'b1, 32'h0000_3002, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_0000;
        #1;
        chk("buf_first_valid", {31'b0, ms2ws_valid}, 32'd1);
        chk("buf_first_wdata", ms_rf_wdata, 32'hFFFF_8001);
        chk("buf_allowin_stall", {31'b0, ms_allowin}, 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h1234_5678;
        #1;
        chk("buf_hold_valid", {31'b0, ms2ws_valid}, 32'd1);
        chk("buf_hold_wdata", ms_rf_wdata, 32'hFFFF_8001);
        tick();
        chk("buf_hold2_wdata", ms_rf_wdata, 32'hFFFF_8001);
        ws_allowin = 1'b1;
        #1;
        chk("buf_release_allowin", {31'b0, ms_allowin}, 32'd1);
        tick();
        chk("buf_left", {31'b0, ms2ws_valid}, 32'd0);

        // Flush an outstanding load; its stale response must be dropped
        issue(32'h1C00_0200, 1'b1, 5'b00001, 1'b1, 32'h0000_4000, 1'b0);
        wb_ex = 1'b1;
        tick();
        wb_ex = 1'b0;
        #1;
        chk("flush_valid", {31'b0, ms2ws_valid}, 32'd0);
        issue(32'h1C00_0204, 1'b1, 5'b00001, 1'b1, 32'h0000_4004, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_0BAD;
        #1;
        chk("stale_not_taken", {31'b0, ms2ws_valid}, 32'd0);
        chk("stale_ld_block", {31'b0, ms_ld_block}, 32'd1);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("stale_gap", {31'b0, ms2ws_valid}, 32'd0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_CAFE;
        #1;
        chk("real_valid", {31'b0, ms2ws_valid}, 32'd1);
        chk("real_wdata", ms_rf_wdata, 32'h0000_CAFE);
        tick();
        data_sram_data_ok = 1'b0;

        // Two flushed loads owe two responses
        issue(32'h1C00_0300, 1'b1, 5'b00001, 1'b1, 32'h0000_5000, 1'b0);
        wb_ex = 1'b1;
        tick();
        wb_ex = 1'b0;
        issue(32'h1C00_0304, 1'b1, 5'b00001, 1'b1, 32'h0000_5004, 1'b0);
        wb_ex = 1'b1;
        tick();
        wb_ex = 1'b0;
        issue(32'h1C00_0308, 1'b1, 5'b00001, 1'b1, 32'h0000_5008, 1'b0);
        for (int k = 0; k < 2; k++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'hBAD0_0000 + 32'(k);
            #1;
            chk($sformatf("stale2_%0d", k), {31'b0, ms2ws_valid}, 32'd0);
            tick();
        end
        data_sram_rdata = 32'h0000_BEEF;
        #1;
        chk("stale2_real_valid", {31'b0, ms2ws_valid}, 32'd1);
        chk("stale2_real_wdata", ms_rf_wdata, 32'h0000_BEEF);
        tick();
        data_sram_data_ok = 1'b0;

        // Flush in the same cycle as the response: consumed, not counted
        issue(32'h1C00_0400, 1'b1, 5'b00001, 1'b1, 32'h0000_6000, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        wb_ex = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        wb_ex = 1'b0;
        #1;
        chk("flush_hit_gone", {31'b0, ms2ws_valid}, 32'd0);
        issue(32'h1C00_0404, 1'b1, 5'b00001, 1'b1, 32'h0000_6004, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_AAAA;
        #1;
        chk("flush_hit_next_valid", {31'b0, ms2ws_valid}, 32'd1);
        chk("flush_hit_next_wdata", ms_rf_wdata, 32'h5555_AAAA);
        tick();
        data_sram_data_ok = 1'b0;

        // Exception instruction: completes without waiting, flush clears it
        ws_allowin = 1'b0;
        issue(32'h1C00_0500, 1'b0, 5'b00000, 1'b1, 32'h0000_0042, 1'b1);
        #1;
        chk("ex_ms_ex", {31'b0, ms_ex}, 32'd1);
        chk("ex_valid", {31'b0, ms2ws_valid}, 32'd1);
        chk("ex_allowin", {31'b0, ms_allowin}, 32'd0);
        wb_ex = 1'b1;
        tick();
        wb_ex = 1'b0;
        ws_allowin = 1'b1;
        #1;
        chk("ex_cleared", {31'b0, ms_ex}, 32'd0);
        chk("ex_cleared_valid", {31'b0, ms2ws_valid}, 32'd0);
        chk("ex_cleared_allowin", {31'b0, ms_allowin}, 32'd1);

        // Asynchronous reset in the middle of a load
        issue(32'h1C00_0600, 1'b1, 5'b00001, 1'b1, 32'h0000_7000, 1'b0);
        #1;
        chk("arst_pre_block", {31'b0, ms_ld_block}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("arst_valid", {31'b0, ms2ws_valid}, 32'd0);
        chk("arst_block", {31'b0, ms_ld_block}, 32'd0);
        chk("arst_allowin", {31'b0, ms_allowin}, 32'd1);
        chk("arst_pc", ms_pc, 32'd0);
        chk("arst_rf_we", {31'b0, ms_rf_we}, 32'd0);
        chk("arst_wdata", ms_rf_wdata, 32'd0);
        #1;
        resetn = 1'b1;
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h7777_7777;
        #1;
        chk("arst_late_ok_valid", {31'b0, ms2ws_valid}, 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("arst_after_valid", {31'b0, ms2ws_valid}, 32'd0);
        issue(32'h1C00_0604, 1'b1, 5'b00001, 1'b1, 32'h0000_7004, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0001;
        #1;
        chk("arst_next_valid", {31'b0, ms2ws_valid}, 32'd1);
        chk("arst_next_wdata", ms_rf_wdata, 32'h0000_0001);
        tick();
        data_sram_data_ok = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
